lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the hart ALU.
- Consumes the ALU result as the effective address, or as a pass-through result for non-memory ops.
- Performs loads, stores, LR/SC and AMO read-modify-write against the data cache over a req/ack handshake.
- Delivers the write-back value with a valid strobe.

Parameters:
- XLEN, 64, data/address width; only 64 supported.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  EX result valid this cycle.
- op_ir  in  15  packed op: [6:0] opcode, [9:7] funct3, [14:10] funct5 (AMO).
- alu_out  in  64  effective address (mem ops) or ALU result (others).
- rs2  in  64  store/AMO source data.
- busy  out  1  unit occupied; upstream holds and must not assert valid_in.
- dc_addr  out  64  cache address, doubleword-aligned ([2:0]=0).
- dc_rd  out  1  read request, held until dc_ack.
- dc_wr  out  1  write request, held until dc_ack.
- dc_be  out  8  byte enables for writes.
- dc_wdata  out  64  lane-positioned write data.
- dc_ack  in  1  single-cycle completion of the current request.
- dc_rdata  in  64  aligned doubleword, valid with dc_ack on reads.
- wb_valid  out  1  one-cycle strobe, result ready.
- wb_data  out  64  write-back value.
- ex_misaligned  out  1  with wb_valid: access misaligned, wb_data = faulting address.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, dc_rd, dc_wr, wb_valid, ex_misaligned, reservation valid = 0.
  - dc_addr, dc_wdata, dc_be, wb_data = 0.
  - Any in-flight request is abandoned; the cache must tolerate a dropped request.
- All outputs are registered.
- Opcodes: load 0000011, store 0100011, amo 0101111; anything else is pass-through.
- Pass-through: valid_in -> wb_valid=1, wb_data=alu_out the next cycle; busy stays 0.
- Size from funct3[1:0] (B/H/W/D). Alignment checked on alu_out[2:0]. AMO/LR/SC allow W or D only.
- Misaligned access: no cache request; next cycle wb_valid=1, ex_misaligned=1, wb_data=alu_out.
- FSM states: IDLE, RD, WR, AMO_RD, AMO_WR, DONE.
  - IDLE + valid_in + load or LR -> RD (dc_rd=1 next cycle).
  - IDLE + valid_in + store -> WR.
  - IDLE + valid_in + SC: reservation hit -> WR; miss -> DONE with result 1.
  - IDLE + valid_in + other AMO -> AMO_RD.
  - RD + dc_ack -> DONE; dc_rd drops the same edge.
  - WR + dc_ack -> DONE.
  - AMO_RD + dc_ack -> AMO_WR: old value latched, new value computed, dc_wr asserted next cycle.
  - AMO_WR + dc_ack -> DONE.
  - DONE -> IDLE; wb_valid=1 for that one cycle.
- busy=1 in every state except IDLE.
- Latency with a zero-wait cache (ack the cycle after request):
  - load/store: 3 cycles valid_in -> wb_valid.
  - AMO: 5 cycles.
- Load extraction: lane = alu_out[2:0].
  - LB/LH/LW sign-extend; LBU/LHU/LWU (funct3 100/101/110) zero-extend; LD raw.
- Stores:
  - dc_wdata = rs2 size-replicated across lanes.
  - dc_be = size mask shifted by alu_out[2:0].
  - wb_data = 0.
- AMO funct5:
  - 00001 swap, 00000 add, 00100 xor, 01100 and, 01000 or.
  - 10000 min, 10100 max, 11000 minu, 11100 maxu.
  - 00010 LR, 00011 SC.
  - W ops act on the 32-bit lane selected by alu_out[2]; min/max compare signed/unsigned 32-bit.
  - wb_data = old memory value, sign-extended for W.
- Reservation (8-byte granule, addr[63:3]):
  - LR sets it.
  - Any SC clears it, hit or miss.
  - A store or AMO write to the reserved granule also clears it.
  - SC result: 0 on success, 1 on failure.
- dc_ack arriving in IDLE or DONE is ignored.
- valid_in while busy is a protocol violation with undefined result; the bench flags it via assertion.

Decomposition:
- Shared package holds:
  - opcode constants (load/store/amo/lui/system/itype/rtype and _w variants);
  - funct3 size codes;
  - AMO funct5 codes;
  - FSM state enum.
- One sub-module, lsu_amo_op (combinational): old value, rs2, funct5, word flag -> new store value.

Test Plan:
- LD at 0x1000, cache returns 0xDEADBEEF_CAFEF00D after 2 wait cycles -> wb_data=0xDEADBEEFCAFEF00D, busy high 4 cycles.
- LB at 0x1007 with rdata 0x80xx_xxxx_xxxx_xxxx -> wb_data=0xFFFFFFFFFFFFFF80; LBU -> 0x80.
- SH rs2=0x1234 at 0x2002 -> dc_be=0x0C, dc_wdata[31:16]=0x1234, dc_addr=0x2000; LW at 0x2002 -> ex_misaligned=1, wb_data=0x2002, no dc_rd.
- AMOADD.W at 0x3004, mem upper word 0x7FFFFFFF, rs2=1 -> written 0x80000000 with dc_be=0xF0; wb_data=0x000000007FFFFFFF.
- LR.D 0x4000; SC.D 0x4000 -> wb_data=0 and write issued; a second SC.D -> wb_data=1, no dc_wr.
- Reset pulsed while dc_rd is held in RD -> dc_rd=0 and busy=0 immediately; a fresh LD afterwards completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, size and AMO codes, FSM states,
// and the lane extraction / replication helpers used by the datapath.
package lsu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_AMO     = 7'b0101111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_ITYPE   = 7'b0010011;
    localparam logic [6:0] OP_RTYPE   = 7'b0110011;
    localparam logic [6:0] OP_ITYPE_W = 7'b0011011;
    localparam logic [6:0] OP_RTYPE_W = 7'b0111011;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StAmoRd,
        StAmoWr,
        StDone
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] sz);
        logic [2:0] low_bits;
        low_bits = {sz == SZ_D, sz[1], sz != SZ_B};
        return (lo & low_bits) != 3'b000;
    endfunction

    // Rotate the addressed lane down to bit 0 and extend by funct3.
    function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                                 input logic [2:0] lo,
                                                 input logic [2:0] f3);
        logic [63:0] sh;
        sh = rdata >> {lo, 3'b000};
        case (f3)
            F3_LB:   return {{56{sh[7]}}, sh[7:0]};
            F3_LH:   return {{48{sh[15]}}, sh[15:0]};
            F3_LW:   return {{32{sh[31]}}, sh[31:0]};
            F3_LBU:  return {56'b0, sh[7:0]};
            F3_LHU:  return {48'b0, sh[15:0]};
            F3_LWU:  return {32'b0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    // Replicate store data across all lanes so the byte enables alone select the target.
    function automatic logic [63:0] store_data(input logic [63:0] d, input logic [1:0] sz);
        case (sz)
            SZ_B:    return {8{d[7:0]}};
            SZ_H:    return {4{d[15:0]}};
            SZ_W:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the EX-side, data-cache and write-back signals of the load/store unit.
interface lsu_if;
    import lsu_pkg::*;

    logic            valid_in;
    logic [14:0]     op_ir;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic [XLEN-1:0] dc_addr;
    logic            dc_rd;
    logic            dc_wr;
    logic [7:0]      dc_be;
    logic [XLEN-1:0] dc_wdata;
    logic            dc_ack;
    logic [XLEN-1:0] dc_rdata;
    logic            wb_valid;
    logic [XLEN-1:0] wb_data;
    logic            ex_misaligned;

    modport master (
        output valid_in, op_ir, alu_out, rs2, dc_ack, dc_rdata,
        input  busy, dc_addr, dc_rd, dc_wr, dc_be, dc_wdata, wb_valid, wb_data, ex_misaligned
    );

    modport slave (
        input  valid_in, op_ir, alu_out, rs2, dc_ack, dc_rdata,
        output busy, dc_addr, dc_rd, dc_wr, dc_be, dc_wdata, wb_valid, wb_data, ex_misaligned
    );
endinterface

// File: rtl/lsu_amo_op.sv
// AMO arithmetic: combines the old memory value with rs2 to form the value written back.
// Word ops use the low 32 bits of both operands; the result is zero-extended.
module lsu_amo_op
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_funct5,
    input  logic            i_word,
    output logic [XLEN-1:0] o_new
);

    logic [31:0] w_a32;
    logic [31:0] w_b32;
    logic [31:0] w_r32;
    logic [63:0] w_r64;
    logic        w_lt32s;
    logic        w_lt32u;
    logic        w_lt64s;
    logic        w_lt64u;

    // Evaluate the op at both widths and pick by the word flag.
    always_comb begin
        w_a32   = i_old[31:0];
        w_b32   = i_rs2[31:0];
        w_lt32s = $signed(w_a32) < $signed(w_b32);
        w_lt32u = w_a32 < w_b32;
        w_lt64s = $signed(i_old) < $signed(i_rs2);
        w_lt64u = i_old < i_rs2;
        w_r32   = w_b32;
        w_r64   = i_rs2;
        case (i_funct5)
            AMO_SWAP: begin w_r32 = w_b32;           w_r64 = i_rs2;           end
            AMO_ADD:  begin w_r32 = w_a32 + w_b32;   w_r64 = i_old + i_rs2;   end
            AMO_XOR:  begin w_r32 = w_a32 ^ w_b32;   w_r64 = i_old ^ i_rs2;   end
            AMO_AND:  begin w_r32 = w_a32 & w_b32;   w_r64 = i_old & i_rs2;   end
            AMO_OR:   begin w_r32 = w_a32 | w_b32;   w_r64 = i_old | i_rs2;   end
            AMO_MIN:  begin
                w_r32 = w_lt32s ? w_a32 : w_b32;
                w_r64 = w_lt64s ? i_old : i_rs2;
            end
            AMO_MAX:  begin
                w_r32 = w_lt32s ? w_b32 : w_a32;
                w_r64 = w_lt64s ? i_rs2 : i_old;
            end
            AMO_MINU: begin
                w_r32 = w_lt32u ? w_a32 : w_b32;
                w_r64 = w_lt64u ? i_old : i_rs2;
            end
            AMO_MAXU: begin
                w_r32 = w_lt32u ? w_b32 : w_a32;
                w_r64 = w_lt64u ? i_rs2 : i_old;
            end
            default:  begin w_r32 = w_b32;           w_r64 = i_rs2;           end
        endcase
        o_new = i_word ? {32'b0, w_r32} : w_r64;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: loads, stores, LR/SC and AMO read-modify-write against the data cache,
// with pass-through of non-memory ALU results. All outputs come straight from flops.
module lsu
    import lsu_pkg::*;
(
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);

    lsu_state_e      r_state, w_state_d;
    logic [XLEN-1:0] r_dc_addr, w_dc_addr_d;
    logic            r_dc_rd, w_dc_rd_d;
    logic            r_dc_wr, w_dc_wr_d;
    logic [7:0]      r_dc_be, w_dc_be_d;
    logic [XLEN-1:0] r_dc_wdata, w_dc_wdata_d;
    logic            r_wb_valid, w_wb_valid_d;
    logic [XLEN-1:0] r_wb_data, w_wb_data_d;
    logic            r_ex_mis, w_ex_mis_d;
    logic            r_busy;
    logic [2:0]      r_funct3, w_funct3_d;
    logic [4:0]      r_funct5, w_funct5_d;
    logic [2:0]      r_lo, w_lo_d;
    logic [XLEN-1:0] r_rs2, w_rs2_d;
    logic [XLEN-1:0] r_result, w_result_d;
    logic            r_resv_valid, w_resv_valid_d;
    logic [60:0]     r_resv_addr, w_resv_addr_d;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_funct5;
    logic [2:0]      w_lo;
    logic            w_is_load, w_is_store, w_is_amo, w_is_lr, w_is_sc;
    logic            w_fault;
    logic            w_granule_hit;
    logic            w_amo_word;
    logic [XLEN-1:0] w_amo_new;

    assign w_opcode      = bus.op_ir[6:0];
    assign w_funct3      = bus.op_ir[9:7];
    assign w_funct5      = bus.op_ir[14:10];
    assign w_lo          = bus.alu_out[2:0];
    assign w_is_load     = w_opcode == OP_LOAD;
    assign w_is_store    = w_opcode == OP_STORE;
    assign w_is_amo      = w_opcode == OP_AMO;
    assign w_is_lr       = w_is_amo && (w_funct5 == AMO_LR);
    assign w_is_sc       = w_is_amo && (w_funct5 == AMO_SC);
    // AMOs only exist at W/D; treat byte/half encodings as an alignment fault.
    assign w_fault       = is_misaligned(w_lo, w_funct3[1:0]) || (w_is_amo && !w_funct3[1]);
    assign w_granule_hit = r_resv_valid && (r_resv_addr == bus.alu_out[63:3]);
    assign w_amo_word    = !r_funct3[0];

    lsu_amo_op u_amo_op (
        .i_old    (r_result),
        .i_rs2    (r_rs2),
        .i_funct5 (r_funct5),
        .i_word   (w_amo_word),
        .o_new    (w_amo_new)
    );

    // Next-state and next-output decode for the access sequencer.
    always_comb begin
        w_state_d      = r_state;
        w_dc_addr_d    = r_dc_addr;
        w_dc_rd_d      = r_dc_rd;
        w_dc_wr_d      = r_dc_wr;
        w_dc_be_d      = r_dc_be;
        w_dc_wdata_d   = r_dc_wdata;
        w_wb_valid_d   = 1'b0;
        w_wb_data_d    = r_wb_data;
        w_ex_mis_d     = 1'b0;
        w_funct3_d     = r_funct3;
        w_funct5_d     = r_funct5;
        w_lo_d         = r_lo;
        w_rs2_d        = r_rs2;
        w_result_d     = r_result;
        w_resv_valid_d = r_resv_valid;
        w_resv_addr_d  = r_resv_addr;

        unique case (r_state)
            StIdle: begin
                if (bus.valid_in) begin
                    if (!(w_is_load || w_is_store || w_is_amo)) begin
                        w_wb_valid_d = 1'b1;
                        w_wb_data_d  = bus.alu_out;
                    end else if (w_fault) begin
                        w_wb_valid_d = 1'b1;
                        w_ex_mis_d   = 1'b1;
                        w_wb_data_d  = bus.alu_out;
                    end else begin
                        w_funct3_d  = w_funct3;
                        w_funct5_d  = w_funct5;
                        w_lo_d      = w_lo;
                        w_rs2_d     = bus.rs2;
                        w_result_d  = '0;
                        w_dc_addr_d = {bus.alu_out[63:3], 3'b000};
                        if (w_is_load || w_is_lr) begin
                            w_state_d = StRd;
                            w_dc_rd_d = 1'b1;
                            if (w_is_lr) begin
                                w_resv_valid_d = 1'b1;
                                w_resv_addr_d  = bus.alu_out[63:3];
                            end
                        end else if (w_is_store || (w_is_sc && w_granule_hit)) begin
                            w_state_d    = StWr;
                            w_dc_wr_d    = 1'b1;
                            w_dc_be_d    = size_mask(w_funct3[1:0]) << w_lo;
                            w_dc_wdata_d = store_data(bus.rs2, w_funct3[1:0]);
                            if (w_is_sc || w_granule_hit) begin
                                w_resv_valid_d = 1'b0;
                            end
                        end else if (w_is_sc) begin
                            w_state_d      = StDone;
                            w_result_d     = 64'd1;
                            w_resv_valid_d = 1'b0;
                        end else begin
                            w_state_d = StAmoRd;
                            w_dc_rd_d = 1'b1;
                            if (w_granule_hit) begin
                                w_resv_valid_d = 1'b0;
                            end
                        end
                    end
                end
            end
            StRd: begin
                if (bus.dc_ack) begin
                    w_dc_rd_d  = 1'b0;
                    w_result_d = load_extract(bus.dc_rdata, r_lo, r_funct3);
                    w_state_d  = StDone;
                end
            end
            StWr: begin
                if (bus.dc_ack) begin
                    w_dc_wr_d = 1'b0;
                    w_state_d = StDone;
                end
            end
            StAmoRd: begin
                // Old value is kept sign-extended: it is both the write-back and the ALU input.
                if (bus.dc_ack) begin
                    w_dc_rd_d  = 1'b0;
                    w_result_d = load_extract(bus.dc_rdata, r_lo, r_funct3);
                    w_state_d  = StAmoWr;
                end
            end
            StAmoWr: begin
                // First cycle computes from the latched old value; the write goes out after.
                if (!r_dc_wr) begin
                    w_dc_wr_d    = 1'b1;
                    w_dc_wdata_d = w_amo_word ? {2{w_amo_new[31:0]}} : w_amo_new;
                    w_dc_be_d    = w_amo_word ? (8'h0F << r_lo) : 8'hFF;
                end else if (bus.dc_ack) begin
                    w_dc_wr_d = 1'b0;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d    = StIdle;
                w_wb_valid_d = 1'b1;
                w_wb_data_d  = r_result;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding cache request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_dc_addr    <= '0;
            r_dc_rd      <= 1'b0;
            r_dc_wr      <= 1'b0;
            r_dc_be      <= '0;
            r_dc_wdata   <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_ex_mis     <= 1'b0;
            r_busy       <= 1'b0;
            r_funct3     <= '0;
            r_funct5     <= '0;
            r_lo         <= '0;
            r_rs2        <= '0;
            r_result     <= '0;
            r_resv_valid <= 1'b0;
            r_resv_addr  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_dc_addr    <= w_dc_addr_d;
            r_dc_rd      <= w_dc_rd_d;
            r_dc_wr      <= w_dc_wr_d;
            r_dc_be      <= w_dc_be_d;
            r_dc_wdata   <= w_dc_wdata_d;
            r_wb_valid   <= w_wb_valid_d;
            r_wb_data    <= w_wb_data_d;
            r_ex_mis     <= w_ex_mis_d;
            r_busy       <= w_state_d != StIdle;
            r_funct3     <= w_funct3_d;
            r_funct5     <= w_funct5_d;
            r_lo         <= w_lo_d;
            r_rs2        <= w_rs2_d;
            r_result     <= w_result_d;
            r_resv_valid <= w_resv_valid_d;
            r_resv_addr  <= w_resv_addr_d;
        end
    end

    assign bus.busy          = r_busy;
    assign bus.dc_addr       = r_dc_addr;
    assign bus.dc_rd         = r_dc_rd;
    assign bus.dc_wr         = r_dc_wr;
    assign bus.dc_be         = r_dc_be;
    assign bus.dc_wdata      = r_dc_wdata;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_data       = r_wb_data;
    assign bus.ex_misaligned = r_ex_mis;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit with a behavioural data cache and a
// write-back scoreboard (value, misaligned flag and latency per operation).
module tb_lsu;
    import lsu_pkg::*;

    logic clk;
    logic rst_n;
    lsu_if bus ();

    lsu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic        mis;
        int          lat;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          waits = 0;
    int          wcnt = 0;
    int          rd_cycles = 0;
    int          wr_count = 0;
    logic [63:0] last_wr_addr = '0;
    logic [7:0]  last_wr_be = '0;
    logic [63:0] last_wr_data = '0;
    logic [63:0] mem [logic [63:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Upstream must never present an op while the unit is busy.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.valid_in && bus.busy)) else begin
                n_fail++;
                $error("FAIL protocol: valid_in=1 while busy=1");
            end
        end
    end

    // Behavioural cache: acks after 'waits' cycles of a held request.
    always @(negedge clk) begin
        logic [63:0] cur;
        bus.dc_ack = 1'b0;
        if (rst_n && (bus.dc_rd || bus.dc_wr)) begin
            if (bus.dc_rd) rd_cycles++;
            if (wcnt >= waits) begin
                wcnt = 0;
                bus.dc_ack = 1'b1;
                cur = mem.exists(bus.dc_addr) ? mem[bus.dc_addr] : 64'd0;
                if (bus.dc_rd) begin
                    bus.dc_rdata = cur;
                end else begin
                    wr_count++;
                    last_wr_addr = bus.dc_addr;
                    last_wr_be   = bus.dc_be;
                    last_wr_data = bus.dc_wdata;
                    for (int b = 0; b < 8; b++) begin
                        if (bus.dc_be[b]) cur[b*8 +: 8] = bus.dc_wdata[b*8 +: 8];
                    end
                    mem[bus.dc_addr] = cur;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Write-back monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.wb_valid) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_wb: observed data=%h with nothing pending", bus.wb_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                assert ({bus.ex_misaligned, bus.wb_data} === {e.mis, e.data}) else begin
                    n_fail++;
                    $error("FAIL %s wb: observed mis=%b data=%h expected mis=%b data=%h",
                           e.tag, bus.ex_misaligned, bus.wb_data, e.mis, e.data);
                end
                n_cmp++;
                assert ((cyc - e.cyc) == e.lat) else begin
                    n_fail++;
                    $error("FAIL %s latency: observed %0d expected %0d",
                           e.tag, cyc - e.cyc, e.lat);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] mk(input logic [4:0] f5, input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f5, f3, opc};
    endfunction

    // Issue one op, queue its expected write-back and wait for it to drain.
    task automatic run(input string tag, input logic [14:0] op, input logic [63:0] addr,
                       input logic [63:0] data, input logic [63:0] exp, input logic mis,
                       input int lat, output int busy_cyc);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.op_ir    = op;
        bus.alu_out  = addr;
        bus.rs2      = data;
        e.data = exp;
        e.mis  = mis;
        e.lat  = lat;
        e.cyc  = cyc;
        e.tag  = tag;
        sb.push_back(e);
        busy_cyc = 0;
        n = 0;
        do begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            if (bus.busy) busy_cyc++;
            n++;
        end while ((sb.size() != 0 || bus.busy) && n < 80);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL %s timeout: observed %0d pending expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int bc;
        int rd0;
        int wr0;

        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.op_ir    = '0;
        bus.alu_out  = '0;
        bus.rs2      = '0;
        bus.dc_ack   = 1'b0;
        bus.dc_rdata = '0;
        mem[64'h1000] = 64'hDEADBEEF_CAFEF00D;
        mem[64'h3000] = 64'h7FFFFFFF_00000055;
        mem[64'h3008] = 64'h00000000_00001111;
        mem[64'h4000] = 64'h00000000_00000042;

        repeat (3) @(negedge clk);
        chk("rst_flags", {59'd0, bus.busy, bus.dc_rd, bus.dc_wr, bus.wb_valid,
                          bus.ex_misaligned}, 64'd0);
        chk("rst_dc_addr", bus.dc_addr, 64'd0);
        chk("rst_dc_wdata", bus.dc_wdata, 64'd0);
        chk("rst_dc_be", {56'd0, bus.dc_be}, 64'd0);
        chk("rst_wb_data", bus.wb_data, 64'd0);
        rst_n = 1'b1;

        run("pass_rtype", mk(5'd0, 3'd0, OP_RTYPE), 64'h12345678_9ABCDEF0, 64'd0,
            64'h12345678_9ABCDEF0, 1'b0, 1, bc);
        chk("pass_busy", bc, 0);

        waits = 2;
        run("ld_wait2", mk(5'd0, F3_LD, OP_LOAD), 64'h1000, 64'd0,
            64'hDEADBEEF_CAFEF00D, 1'b0, 5, bc);
        chk("ld_busy_cycles", bc, 4);
        waits = 0;

        mem[64'h1000] = 64'h80112233_44556677;
        run("lb", mk(5'd0, F3_LB, OP_LOAD), 64'h1007, 64'd0,
            64'hFFFFFFFF_FFFFFF80, 1'b0, 3, bc);
        run("lbu", mk(5'd0, F3_LBU, OP_LOAD), 64'h1007, 64'd0, 64'h80, 1'b0, 3, bc);
        run("lh", mk(5'd0, F3_LH, OP_LOAD), 64'h1004, 64'd0,
            64'hFFFFFFFF_FFFF2233 & 64'h00000000_00002233 | 64'h2233, 1'b0, 3, bc);

        run("sh", mk(5'd0, 3'b001, OP_STORE), 64'h2002, 64'h1234, 64'd0, 1'b0, 3, bc);
        chk("sh_addr", last_wr_addr, 64'h2000);
        chk("sh_be", {56'd0, last_wr_be}, 64'h0C);
        chk("sh_wdata", last_wr_data, 64'h12341234_12341234);
        run("ld_after_sh", mk(5'd0, F3_LD, OP_LOAD), 64'h2000, 64'd0,
            64'h00000000_12340000, 1'b0, 3, bc);

        rd0 = rd_cycles;
        run("lw_misaligned", mk(5'd0, F3_LW, OP_LOAD), 64'h2002, 64'd0,
            64'h2002, 1'b1, 1, bc);
        chk("lw_mis_no_rd", rd_cycles - rd0, 0);

        run("amoadd_w", mk(AMO_ADD, 3'b010, OP_AMO), 64'h3004, 64'd1,
            64'h00000000_7FFFFFFF, 1'b0, 5, bc);
        chk("amoadd_be", {56'd0, last_wr_be}, 64'hF0);
        chk("amoadd_wdata", last_wr_data, 64'h80000000_80000000);
        run("amomin_w", mk(AMO_MIN, 3'b010, OP_AMO), 64'h3000, 64'hFFFFFFFF,
            64'h00000000_00000055, 1'b0, 5, bc);
        run("ld_after_amo", mk(5'd0, F3_LD, OP_LOAD), 64'h3000, 64'd0,
            64'h80000000_FFFFFFFF, 1'b0, 3, bc);
        run("amoswap_d", mk(AMO_SWAP, 3'b011, OP_AMO), 64'h3008, 64'hAAAABBBB_CCCCDDDD,
            64'h1111, 1'b0, 5, bc);
        run("ld_after_swap", mk(5'd0, F3_LD, OP_LOAD), 64'h3008, 64'd0,
            64'hAAAABBBB_CCCCDDDD, 1'b0, 3, bc);

        run("lr_d", mk(AMO_LR, 3'b011, OP_AMO), 64'h4000, 64'd0, 64'h42, 1'b0, 3, bc);
        wr0 = wr_count;
        run("sc_d_hit", mk(AMO_SC, 3'b011, OP_AMO), 64'h4000, 64'h99, 64'd0, 1'b0, 3, bc);
        chk("sc_hit_wrote", wr_count - wr0, 1);
        wr0 = wr_count;
        run("sc_d_miss", mk(AMO_SC, 3'b011, OP_AMO), 64'h4000, 64'h77, 64'd1, 1'b0, 2, bc);
        chk("sc_miss_no_wr", wr_count - wr0, 0);
        run("lr_d_2", mk(AMO_LR, 3'b011, OP_AMO), 64'h4000, 64'd0, 64'h99, 1'b0, 3, bc);
        run("sd_clear", mk(5'd0, 3'b011, OP_STORE), 64'h4000, 64'h5, 64'd0, 1'b0, 3, bc);
        run("sc_after_sd", mk(AMO_SC, 3'b011, OP_AMO), 64'h4000, 64'h7, 64'd1, 1'b0, 2, bc);

        // Reset while a read is held outstanding.
        waits = 100;
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.op_ir    = mk(5'd0, F3_LD, OP_LOAD);
        bus.alu_out  = 64'h1000;
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("rd_held", {63'd0, bus.dc_rd}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drops_rd", {63'd0, bus.dc_rd}, 64'd0);
        chk("rst_drops_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waits = 0;
        run("ld_after_rst", mk(5'd0, F3_LD, OP_LOAD), 64'h1000, 64'd0,
            64'h80112233_44556677, 1'b0, 3, bc);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
